reg_bank: RTL
=============

Name: reg_bank

Overview:
- Parametrised successor to the two-register demo DUT: a bank of NUM_REGS registers, each DWIDTH bits wide, on the same reg_op/reg_addr/reg_wdata bus.
- Adds a configurable read pipeline latency, a read-valid strobe, an address-error strobe and a write-one-to-clear operation.
- Sits behind the register agent as the register target the UVM bench drives and scoreboards.

Parameters:
DWIDTH, 8, register and data-bus width (1..64)
AWIDTH, 8, address width; requires NUM_REGS < 2**AWIDTH
NUM_REGS, 4, number of implemented registers, addresses 0..NUM_REGS-1 (1..64)
RD_LATENCY, 1, cycles from op issue to response (1..4)
RST_VAL, 0, reset value loaded into every register (DWIDTH bits)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
reg_op  input  2  operation: 0 NOP, 1 RD, 2 WR, 3 W1C
reg_addr  input  AWIDTH  register address
reg_wdata  input  DWIDTH  write data, or clear mask for W1C
reg_rdata  output  DWIDTH  read data, valid when reg_rvalid=1
reg_rvalid  output  1  one-cycle pulse per RD, RD_LATENCY cycles after issue
reg_err  output  1  one-cycle pulse, RD_LATENCY cycles after any RD/WR/W1C to a bad address

Behaviour:
- Interface: one clock (clk); reset is rst_n, asynchronous assert, active-low. Release is synchronised externally.
- Reset (rst_n=0): every register = RST_VAL; reg_rdata=0, reg_rvalid=0, reg_err=0; the response pipeline is flushed. In-flight reads are dropped and never produce reg_rvalid.
- One op per cycle, sampled on the rising edge. No backpressure: a new op may issue every cycle.
- Address check: reg_addr >= NUM_REGS is out of range, unless it is LOCK_ADDR with the optional feature compiled in.
- WR in range: reg[addr] <= reg_wdata at the issuing edge.
- W1C in range: reg[addr] <= reg[addr] & ~reg_wdata at the issuing edge.
- RD in range: reg[addr] is sampled at the issuing edge. The value already includes any write committed at an earlier edge, so WR in cycle N followed by RD of the same address in cycle N+1 returns the new value.
- RD out of range: response data = 0, reg_err=1.
- WR/W1C out of range: no register changes; reg_err pulses.
- NOP: no state change, no response.
- Pipeline: a shift register of depth RD_LATENCY carrying {valid, err, data}. reg_rvalid/reg_err appear exactly RD_LATENCY cycles after issue.
- reg_rvalid and reg_err are 1-cycle pulses per op. Back-to-back reads give back-to-back pulses.
- reg_rdata updates only when reg_rvalid=1 and holds its last value otherwise.
- reg_err for WR/W1C is never accompanied by reg_rvalid.
- Address decode uses the full AWIDTH. No aliasing: for example, NUM_REGS=4 with addr 'h04 is an error, not reg0.

Optional Feature:
- Macro: REG_BANK_LOCK_EN.
- With the macro, a lock register is added at LOCK_ADDR = NUM_REGS:
  - WR with wdata[0]=1 to LOCK_ADDR sets lock; lock is sticky until rst_n. WR with wdata[0]=0, or W1C, has no effect on lock and raises no error.
  - RD of LOCK_ADDR returns {DWIDTH-1 zeros, lock}.
  - While lock=1, WR/W1C to registers 0..NUM_REGS-1 are ignored and pulse reg_err. Reads are unaffected.
- Without the macro, no lock logic exists and LOCK_ADDR behaves as any out-of-range address.

Test Plan:
1. Reset check, defaults with RST_VAL='h5A: drop rst_n mid-stream, then RD addr 0..3 -> reg_rdata='h5A each with reg_rvalid pulse, reg_err=0. An RD issued the cycle before reset produces no reg_rvalid.
2. WR/RD with RD_LATENCY=3: WR addr 1 data 'hC3, RD addr 1 next cycle -> reg_rvalid exactly 3 cycles after the RD, reg_rdata='hC3. Back-to-back RD 0,1,2 -> 3 consecutive rvalid pulses, in order.
3. W1C: WR addr 2 'hFF, W1C addr 2 mask 'h0F, RD addr 2 -> 'hF0. W1C mask 'h00 -> value unchanged.
4. Out of range, NUM_REGS=4: WR addr 'h04 'hAA -> reg_err pulse, no reg_rvalid, registers unchanged. RD addr 'hFF -> reg_rvalid=1, reg_err=1, reg_rdata=0.
5. Async reset mid-pipeline: with RD_LATENCY=4, issue RD then assert rst_n low between clock edges -> all outputs 0 immediately, no later rvalid.
6. REG_BANK_LOCK_EN: WR LOCK_ADDR 'h01, WR addr 0 'h77 -> reg_err pulse and reg0 unchanged. RD LOCK_ADDR -> 'h01. After reset, WR addr 0 'h77 succeeds.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: a bank of NUM_REGS registers, each DWIDTH bits wide, on a simple reg_op/reg_addr/reg_wdata bus.
// Reads, writes and write-one-to-clear operations share the bus.
// Responses (read data, read-valid strobe and address-error strobe) leave a fixed-depth pipeline
// RD_LATENCY cycles after the operation issues.
//
// Optional feature, macro REG_BANK_LOCK_EN:
//   Adds a sticky lock register at address NUM_REGS. While the lock is set, register updates are
//   refused and flagged as errors.
//
// Ports:
//   clk        - clock; all logic uses the rising edge
//   rst_n      - asynchronous active-low reset
//   reg_op     - operation: 0 NOP, 1 RD, 2 WR, 3 W1C
//   reg_addr   - register address, decoded over the full AWIDTH
//   reg_wdata  - write data, or the clear mask for W1C
//   reg_rdata  - read data; holds its last value between reg_rvalid pulses
//   reg_rvalid - one-cycle pulse per RD, RD_LATENCY cycles after issue
//   reg_err    - one-cycle pulse per operation to a bad (or locked) address
module reg_bank #(
  parameter int unsigned      DWIDTH     = 8,
  parameter int unsigned      AWIDTH     = 8,
  parameter int unsigned      NUM_REGS   = 4,
  parameter int unsigned      RD_LATENCY = 1,
  parameter logic [DWIDTH-1:0] RST_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        reg_op,
  input  logic [AWIDTH-1:0] reg_addr,
  input  logic [DWIDTH-1:0] reg_wdata,
  output logic [DWIDTH-1:0] reg_rdata,
  output logic              reg_rvalid,
  output logic              reg_err
);

  localparam logic [1:0]        OP_RD     = 2'd1;
  localparam logic [1:0]        OP_WR     = 2'd2;
  localparam logic [1:0]        OP_W1C    = 2'd3;
  localparam logic [AWIDTH-1:0] LOCK_ADDR = AWIDTH'(NUM_REGS);

  logic [DWIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] hit_c;
  logic [DWIDTH-1:0] rd_val_c;
  logic [DWIDTH-1:0] new_val_c;
  logic [DWIDTH-1:0] s_data_c;
  logic is_rd_c, is_upd_c, in_range_c, lock_hit_c, locked_c, wr_en_c, err_c;

  logic [RD_LATENCY-1:0]             pipe_vld;
  logic [RD_LATENCY-1:0]             pipe_err;
  logic [RD_LATENCY-1:0][DWIDTH-1:0] pipe_data;

`ifdef REG_BANK_LOCK_EN
  logic lock_q;

  // Sticky lock: set by a WR of bit 0 to LOCK_ADDR, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (reg_op == OP_WR && lock_hit_c && reg_wdata[0]) begin
      lock_q <= 1'b1;
    end
  end

  assign lock_hit_c = (reg_addr == LOCK_ADDR);
  assign locked_c   = lock_q;
`else
  assign lock_hit_c = 1'b0;
  assign locked_c   = 1'b0;
`endif

  // One-hot address decode over the full address width, so there is no aliasing.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_hit
    assign hit_c[g] = (reg_addr == AWIDTH'(g));
  end

  // Op decode, read mux, and the response word entering the pipeline.
  always_comb begin
    is_rd_c    = (reg_op == OP_RD);
    is_upd_c   = (reg_op == OP_WR) || (reg_op == OP_W1C);
    in_range_c = (reg_addr < LOCK_ADDR);
    rd_val_c   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rd_val_c = rd_val_c | ({DWIDTH{hit_c[i]}} & regs[i]);
    end
    new_val_c = (reg_op == OP_WR) ? reg_wdata : (rd_val_c & ~reg_wdata);
    wr_en_c   = is_upd_c && in_range_c && !locked_c;
    // LOCK_ADDR is never an error; in-range updates error only while locked.
    err_c = (is_rd_c && !in_range_c && !lock_hit_c) ||
            (is_upd_c && ((!in_range_c && !lock_hit_c) || (in_range_c && locked_c)));
    if (in_range_c) begin
      s_data_c = rd_val_c;
    end else if (lock_hit_c) begin
      s_data_c = DWIDTH'(locked_c);
    end else begin
      s_data_c = '0;
    end
  end

  // Register array: WR overwrites, W1C clears the masked bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_VAL;
      end
    end else if (wr_en_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (hit_c[i]) begin
          regs[i] <= new_val_c;
        end
      end
    end
  end

  // Response pipeline. A data stage loads only when a valid read enters it, so the last stage
  // doubles as the held reg_rdata value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_err  <= '0;
      pipe_data <= '0;
    end else begin
      pipe_vld <= (pipe_vld << 1) | RD_LATENCY'(is_rd_c);
      pipe_err <= (pipe_err << 1) | RD_LATENCY'(err_c);
      if (is_rd_c) begin
        pipe_data[0] <= s_data_c;
      end
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign reg_rvalid = pipe_vld[RD_LATENCY-1];
  assign reg_err    = pipe_err[RD_LATENCY-1];
  assign reg_rdata  = pipe_data[RD_LATENCY-1];

endmodule
